text_console_ctrl: RTL and testbench
====================================

TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 Parameter COLS, default 70, characters per text row.
REQ-002 Parameter ROWS, default 30, text rows on screen.
REQ-003 Parameter COL_W, default 7, column index width, at least clog2(COLS).
REQ-004 Parameter ROW_W, default 5, row index width, at least clog2(ROWS).
REQ-005 Port clk, in, 1, single system clock; all logic on its rising edge.
REQ-006 Port clrn, in, 1, reset, asynchronous and active-low.
REQ-007 Port key_valid, in, 1, keystroke strobe from the keyboard block.
REQ-008 Port key_ascii, in, 8, ASCII code qualified by key_valid.
REQ-009 Port key_ready, out, 1, high when a keystroke is accepted this cycle.
REQ-010 Port rd_row, in, ROW_W, screen (logical) row requested by the VGA path.
REQ-011 Port rd_col, in, COL_W, screen column requested by the VGA path.
REQ-012 Port rd_ascii, out, 8, character at (rd_row, rd_col).
REQ-013 Port cur_row, out, ROW_W, cursor logical row.
REQ-014 Port cur_col, out, COL_W, cursor column.
REQ-015 Port last_ascii, out, 8, last accepted code, for hex display.

Function
REQ-016 The block SHALL accept a keystroke only on a cycle where key_valid=1 and key_ready=1; key_valid while key_ready=0 SHALL be dropped, not queued.
REQ-017 States SHALL be: CLR_ALL, IDLE and CLR_LINE; key_ready=1 only in IDLE.
REQ-018 For a printable code 0x20..0x7E, the block SHALL write the code at the cursor in the accept cycle, then advance the column; at COLS-1 it SHALL set the column to 0 and perform a newline.
REQ-019 For 0x0D, the block SHALL perform a newline with no write.
REQ-020 For 0x08 with col>0: col-1, then write 0x20 there. With col=0 and row>0: row-1, col=COLS-1, write 0x20 there. At (0,0): no action.
REQ-021 For any other code, only last_ascii SHALL update; last_ascii SHALL update on every accept.
REQ-022 Newline: column to 0; if row<ROWS-1, row+1; else row stays ROWS-1, top pointer becomes (top+1) mod ROWS, and the state goes to CLR_LINE.
REQ-023 CLR_LINE SHALL write 0x20 to the new bottom physical row, one cell per cycle, for COLS cycles, then return to IDLE.
REQ-024 Physical row SHALL be (logical row + top) mod ROWS, computed without a divider; write address SHALL be phys_row*COLS+col.
REQ-025 rd_ascii SHALL have 1-cycle latency from rd_row/rd_col; rd_ascii SHALL be 0x00 for rd_col>=COLS or rd_row>=ROWS.
REQ-026 A read and a write to the same cell in one cycle SHALL return the old data.

Reset
REQ-027 While clrn=0: cursor (0,0), top=0, last_ascii=0x00, rd_ascii=0x00, key_ready=0, state CLR_ALL.
REQ-028 CLR_ALL SHALL write 0x20 to all ROWS*COLS cells, one per cycle, from address 0, then enter IDLE.
REQ-029 A reset asserted mid-clear or mid-operation SHALL restart CLR_ALL from address 0.

Structure
REQ-030 A shared package SHALL hold the state enum and the constants CH_SPACE=0x20, CH_CR=0x0D, CH_BS=0x08, CH_PRN_LO=0x20 and CH_PRN_HI=0x7E.
REQ-031 Storage SHALL be one sub-module text_ram: simple dual-port RAM, depth ROWS*COLS, 8-bit, synchronous write and registered read, no reset.

Verification (COLS=4, ROWS=3)
REQ-032 Release reset -> key_ready low for exactly 12 cycles, then high; every cell reads 0x20.
REQ-033 Send 'A','B','C','D' -> row 0 reads 41 42 43 44; cursor ends at (1,0).
REQ-034 Send 'X', then 0x08, then 0x08 -> cell (1,0)=0x20; second backspace moves cursor to (0,3) and writes 0x20 at (0,3).
REQ-035 Cursor at (2,0), send 0x0D -> top=1; key_ready low for 4 cycles; logical row 2 reads all 0x20; old logical row 1 now appears at rd_row 0.
REQ-036 Send key_valid during CLR_LINE -> key dropped; memory and last_ascii unchanged.
REQ-037 Send 0x1B -> last_ascii=0x1B; cursor and memory unchanged.

Source files
------------

// File: rtl/text_console_ctrl_pkg.sv
// Shared types and constants for the text console: FSM states, control codes
// and the row/address arithmetic used by both the write and read paths.
package text_console_ctrl_pkg;

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        CLR_LINE = 2'd2
    } state_t;

    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_BS     = 8'h08;
    localparam logic [7:0] CH_PRN_LO = 8'h20;
    localparam logic [7:0] CH_PRN_HI = 8'h7E;

    // Both operands are already below rows, so one conditional subtract replaces a modulo.
    function automatic int unsigned wrap_row(input int unsigned row, input int unsigned top,
                                             input int unsigned rows);
        int unsigned s;
        s = row + top;
        return (s >= rows) ? s - rows : s;
    endfunction

    function automatic int unsigned cell_addr(input int unsigned lrow, input int unsigned col,
                                              input int unsigned top, input int unsigned rows,
                                              input int unsigned cols);
        return wrap_row(lrow, top, rows) * cols + col;
    endfunction

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_PRN_LO) && (c <= CH_PRN_HI);
    endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Keyboard, VGA read and status signals of the text console, bundled with
// master (keyboard/VGA side) and slave (console) views.
interface text_console_ctrl_if #(
    parameter int COL_W = 7,
    parameter int ROW_W = 5
) ();
    import text_console_ctrl_pkg::*;

    // Keystroke handshake: a code transfers on a rising edge where key_valid and
    // key_ready are both high; key_valid while key_ready is low is simply dropped.
    logic             key_valid;
    logic [7:0]       key_ascii;
    logic             key_ready;
    logic [ROW_W-1:0] rd_row;
    logic [COL_W-1:0] rd_col;
    logic [7:0]       rd_ascii;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic [7:0]       last_ascii;
    state_t           dbg_state;

    modport master (
        output key_valid, key_ascii, rd_row, rd_col,
        input  key_ready, rd_ascii, cur_row, cur_col, last_ascii, dbg_state
    );

    modport slave (
        input  key_valid, key_ascii, rd_row, rd_col,
        output key_ready, rd_ascii, cur_row, cur_col, last_ascii, dbg_state
    );

endinterface

// File: rtl/text_console_ctrl_text_ram.sv
// Character store: simple dual-port RAM with synchronous write and registered
// read; a same-cycle read of the cell being written returns the old byte.
module text_ram #(
    parameter int DEPTH = 2100,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/text_console_ctrl.sv
// Text console controller: turns keystrokes into cursor moves and character
// writes on a scrolling ring of text rows, and serves character reads to VGA.
module text_console_ctrl
    import text_console_ctrl_pkg::*;
#(
    parameter int COLS  = 70,
    parameter int ROWS  = 30,
    parameter int COL_W = 7,
    parameter int ROW_W = 5
) (
    input  logic                clk,
    input  logic                clrn,
    text_console_ctrl_if.slave  bus
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state_q;
    logic             key_ready_q;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] top_q;
    logic [COL_W-1:0] col_q;
    logic [7:0]       last_q;
    logic [AW-1:0]    clr_cnt_q;
    logic             rd_in_range_q;

    logic             accept;
    logic [7:0]       key;
    logic             key_prn;
    logic             at_last_col;
    logic             at_last_row;
    logic             newline_req;
    logic [ROW_W-1:0] next_top;

    assign key         = bus.key_ascii;
    assign accept      = bus.key_valid & key_ready_q;
    assign key_prn     = is_printable(key);
    assign at_last_col = (col_q == COL_W'(COLS - 1));
    assign at_last_row = (row_q == ROW_W'(ROWS - 1));
    assign newline_req = (key_prn && at_last_col) || (key == CH_CR);
    assign next_top    = ROW_W'(wrap_row(32'(top_q), 32'd1, 32'(ROWS)));

    // Candidate write addresses; the logical-to-physical row mapping goes through top_q.
    logic [AW-1:0] addr_cur;
    logic [AW-1:0] addr_bs_col;
    logic [AW-1:0] addr_bs_row;
    logic [AW-1:0] addr_clr_line;
    logic [AW-1:0] rd_addr;
    logic          rd_in_range;

    assign addr_cur      = AW'(cell_addr(32'(row_q), 32'(col_q), 32'(top_q), ROWS, COLS));
    assign addr_bs_col   = AW'(cell_addr(32'(row_q), 32'(col_q) - 32'd1, 32'(top_q), ROWS, COLS));
    assign addr_bs_row   = AW'(cell_addr(32'(row_q) - 32'd1, 32'(COLS - 1), 32'(top_q), ROWS, COLS));
    assign addr_clr_line = AW'(cell_addr(32'(ROWS - 1), 32'(clr_cnt_q), 32'(top_q), ROWS, COLS));

    assign rd_in_range = (32'(bus.rd_row) < 32'(ROWS)) && (32'(bus.rd_col) < 32'(COLS));
    assign rd_addr     = rd_in_range
                       ? AW'(cell_addr(32'(bus.rd_row), 32'(bus.rd_col), 32'(top_q), ROWS, COLS))
                       : '0;

    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = CH_SPACE;
        case (state_q)
            CLR_ALL: begin
                we    = 1'b1;
                waddr = clr_cnt_q;
            end
            CLR_LINE: begin
                we    = 1'b1;
                waddr = addr_clr_line;
            end
            IDLE: begin
                if (accept) begin
                    if (key_prn) begin
                        we    = 1'b1;
                        waddr = addr_cur;
                        wdata = key;
                    end else if (key == CH_BS) begin
                        if (col_q != '0) begin
                            we    = 1'b1;
                            waddr = addr_bs_col;
                        end else if (row_q != '0) begin
                            we    = 1'b1;
                            waddr = addr_bs_row;
                        end
                    end
                end
            end
            default: begin
                we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q       <= CLR_ALL;
            key_ready_q   <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            top_q         <= '0;
            last_q        <= 8'h00;
            clr_cnt_q     <= '0;
            rd_in_range_q <= 1'b0;
        end else begin
            rd_in_range_q <= rd_in_range;
            case (state_q)
                CLR_ALL: begin
                    if (clr_cnt_q == AW'(DEPTH - 1)) begin
                        state_q     <= IDLE;
                        key_ready_q <= 1'b1;
                        clr_cnt_q   <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                CLR_LINE: begin
                    if (clr_cnt_q == AW'(COLS - 1)) begin
                        state_q     <= IDLE;
                        key_ready_q <= 1'b1;
                        clr_cnt_q   <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        last_q <= key;
                        if (key_prn && !at_last_col) begin
                            col_q <= col_q + 1'b1;
                        end else if (newline_req) begin
                            col_q <= '0;
                            if (!at_last_row) begin
                                row_q <= row_q + 1'b1;
                            end else begin
                                // Bottom row: scroll by moving the ring's top, then blank the reused row.
                                top_q       <= next_top;
                                state_q     <= CLR_LINE;
                                key_ready_q <= 1'b0;
                                clr_cnt_q   <= '0;
                            end
                        end else if (key == CH_BS) begin
                            if (col_q != '0) begin
                                col_q <= col_q - 1'b1;
                            end else if (row_q != '0) begin
                                row_q <= row_q - 1'b1;
                                col_q <= COL_W'(COLS - 1);
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= CLR_ALL;
                    key_ready_q <= 1'b0;
                    clr_cnt_q   <= '0;
                end
            endcase
        end
    end

    logic [7:0] ram_rdata;

    text_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_text_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    assign bus.key_ready  = key_ready_q;
    assign bus.rd_ascii   = rd_in_range_q ? ram_rdata : 8'h00;
    assign bus.cur_row    = row_q;
    assign bus.cur_col    = col_q;
    assign bus.last_ascii = last_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl on a 4x3 screen: directed scenarios plus random
// keystrokes, checked against a row-list model of the visible screen.
module tb_text_console_ctrl;
    import text_console_ctrl_pkg::*;

    localparam int COLS  = 4;
    localparam int ROWS  = 3;
    localparam int COL_W = 3;
    localparam int ROW_W = 2;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    text_console_ctrl_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

    text_console_ctrl #(
        .COLS (COLS), .ROWS (ROWS), .COL_W (COL_W), .ROW_W (ROW_W)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the visible screen in logical order; scrolling drops row 0 and appends a blank row.
    logic [7:0] m_cell [ROWS*COLS];
    int         m_row;
    int         m_col;
    logic [7:0] m_last;
    logic [7:0] exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < ROWS*COLS; i++) m_cell[i] = 8'h20;
        m_row  = 0;
        m_col  = 0;
        m_last = 8'h00;
    endtask

    task automatic model_newline(output int busy);
        busy  = 0;
        m_col = 0;
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) m_cell[r*COLS+c] = m_cell[(r+1)*COLS+c];
            for (int c = 0; c < COLS; c++) m_cell[(ROWS-1)*COLS+c] = 8'h20;
            busy = COLS;
        end
    endtask

    task automatic model_key(input logic [7:0] a, output int busy);
        busy   = 0;
        m_last = a;
        if (a >= 8'h20 && a <= 8'h7E) begin
            m_cell[m_row*COLS+m_col] = a;
            if (m_col == COLS - 1) model_newline(busy);
            else m_col++;
        end else if (a == 8'h0D) begin
            model_newline(busy);
        end else if (a == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_cell[m_row*COLS+m_col] = 8'h20;
            end else if (m_row > 0) begin
                m_row--;
                m_col = COLS - 1;
                m_cell[m_row*COLS+m_col] = 8'h20;
            end
        end
    endtask

    // Counts negedge samples with key_ready low; exp_low < 0 means only the timeout is checked.
    task automatic wait_ready(input string tag, input int exp_low);
        int lows;
        lows = 0;
        while (bus.key_ready !== 1'b1 && lows < 200) begin
            lows++;
            @(negedge clk);
        end
        if (lows >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s key_ready timeout after %0d cycles", tag, lows);
        end else if (exp_low >= 0) begin
            n_checks++;
            if (lows != exp_low) begin
                n_fail++;
                $display("FAIL %s key_ready low cycles got %0d exp %0d", tag, lows, exp_low);
            end
        end
    endtask

    task automatic send_key(input logic [7:0] a, output int busy);
        wait_ready("send_wait", -1);
        bus.key_valid = 1'b1;
        bus.key_ascii = a;
        @(negedge clk);
        bus.key_valid = 1'b0;
        model_key(a, busy);
    endtask

    task automatic scoreboard_scan(input string tag);
        logic [7:0] exp;
        logic [7:0] got;
        for (int r = 0; r <= ROWS; r++) begin
            for (int c = 0; c <= COLS + 1; c++) begin
                bus.rd_row = ROW_W'(r);
                bus.rd_col = COL_W'(c);
                if (r < ROWS && c < COLS) exp_q.push_back(m_cell[r*COLS+c]);
                else exp_q.push_back(8'h00);
                @(negedge clk);
                exp = exp_q.pop_front();
                got = bus.rd_ascii;
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL %s rd(%0d,%0d) got %02h exp %02h", tag, r, c, got, exp);
                end
            end
        end
    endtask

    task automatic check_cursor(input string tag, input int er, input int ec, input logic [7:0] el);
        n_checks++;
        if (bus.cur_row !== ROW_W'(er) || bus.cur_col !== COL_W'(ec) || bus.last_ascii !== el) begin
            n_fail++;
            $display("FAIL %s cursor/last got (%0d,%0d) %02h exp (%0d,%0d) %02h", tag,
                     bus.cur_row, bus.cur_col, bus.last_ascii, er, ec, el);
        end
    endtask

    task automatic test_reset();
        clrn          = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_ascii = 8'h00;
        bus.rd_row    = '0;
        bus.rd_col    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.key_ready !== 1'b0 || bus.rd_ascii !== 8'h00 || bus.dbg_state !== CLR_ALL) begin
            n_fail++;
            $display("FAIL reset_outputs got ready=%b rd=%02h st=%0d exp 0 00 %0d",
                     bus.key_ready, bus.rd_ascii, bus.dbg_state, CLR_ALL);
        end
        check_cursor("reset_cursor", 0, 0, 8'h00);
        clrn = 1'b1;
        wait_ready("reset_clear", ROWS*COLS);
        scoreboard_scan("reset_screen");
    endtask

    task automatic test_fill_row();
        int busy;
        send_key(8'h41, busy);
        send_key(8'h42, busy);
        send_key(8'h43, busy);
        send_key(8'h44, busy);
        check_cursor("fill_cursor", 1, 0, 8'h44);
        scoreboard_scan("fill_screen");
    endtask

    task automatic test_backspace();
        int busy;
        send_key(8'h58, busy);
        send_key(8'h08, busy);
        check_cursor("bs_col", 1, 0, 8'h08);
        send_key(8'h08, busy);
        check_cursor("bs_wrap", 0, 3, 8'h08);
        scoreboard_scan("bs_screen");
    endtask

    task automatic test_scroll();
        int busy;
        send_key(8'h0D, busy);
        send_key(8'h45, busy);
        send_key(8'h46, busy);
        send_key(8'h0D, busy);
        check_cursor("pre_scroll", 2, 0, 8'h0D);
        send_key(8'h0D, busy);
        wait_ready("scroll_busy", 4);
        check_cursor("post_scroll", 2, 0, 8'h0D);
        bus.rd_row = 2'd0;
        bus.rd_col = 3'd0;
        @(negedge clk);
        n_checks++;
        if (bus.rd_ascii !== 8'h45) begin
            n_fail++;
            $display("FAIL scroll_row0 got %02h exp 45", bus.rd_ascii);
        end
        scoreboard_scan("scroll_screen");
    endtask

    task automatic test_drop_in_clr_line();
        int busy;
        send_key(8'h0D, busy);
        bus.key_valid = 1'b1;
        bus.key_ascii = 8'h5A;
        n_checks++;
        if (bus.key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_busy key_ready got %b exp 0", bus.key_ready);
        end
        @(negedge clk);
        @(negedge clk);
        bus.key_valid = 1'b0;
        wait_ready("drop_remaining", 2);
        check_cursor("drop_cursor", 2, 0, 8'h0D);
        scoreboard_scan("drop_screen");
    endtask

    task automatic test_other_code();
        int busy;
        int r0, c0;
        r0 = m_row;
        c0 = m_col;
        send_key(8'h1B, busy);
        check_cursor("esc_cursor", r0, c0, 8'h1B);
        scoreboard_scan("esc_screen");
    endtask

    task automatic test_reset_restart();
        int busy;
        send_key(8'h61, busy);
        #2 clrn = 1'b0;
        #1;
        n_checks++;
        if (bus.key_ready !== 1'b0 || bus.cur_row !== '0 || bus.cur_col !== '0 ||
            bus.last_ascii !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset got ready=%b cur=(%0d,%0d) last=%02h exp 0 (0,0) 00",
                     bus.key_ready, bus.cur_row, bus.cur_col, bus.last_ascii);
        end
        @(negedge clk);
        clrn = 1'b1;
        repeat (5) @(negedge clk);
        #3 clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        model_reset();
        wait_ready("restart_clear", ROWS*COLS);
        scoreboard_scan("restart_screen");
    endtask

    task automatic test_collision();
        int busy;
        logic [7:0] exp;
        bus.rd_row = ROW_W'(m_row);
        bus.rd_col = COL_W'(m_col);
        exp_q.push_back(m_cell[m_row*COLS+m_col]);
        exp_q.push_back(8'h51);
        send_key(8'h51, busy);
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.rd_ascii !== exp) begin
            n_fail++;
            $display("FAIL collision_old got %02h exp %02h", bus.rd_ascii, exp);
        end
        @(negedge clk);
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.rd_ascii !== exp) begin
            n_fail++;
            $display("FAIL collision_new got %02h exp %02h", bus.rd_ascii, exp);
        end
    endtask

    task automatic test_random();
        int busy;
        int kind;
        logic [7:0] a;
        for (int i = 0; i < 160; i++) begin
            kind = $urandom_range(0, 99);
            if (kind < 50)      a = 8'($urandom_range(32'h20, 32'h7E));
            else if (kind < 65) a = 8'h0D;
            else if (kind < 85) a = 8'h08;
            else if (kind < 92) a = 8'($urandom_range(32'h00, 32'h1F));
            else                a = 8'($urandom_range(32'h7F, 32'hFF));
            if (kind >= 85 && (a == 8'h08 || a == 8'h0D)) a = 8'h1B;
            send_key(a, busy);
            wait_ready("rand_busy", busy);
            check_cursor("rand_cursor", m_row, m_col, m_last);
            if ((i % 40) == 39) scoreboard_scan("rand_screen");
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_fill_row();
        test_backspace();
        test_scroll();
        test_drop_in_clr_line();
        test_other_code();
        test_reset_restart();
        test_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
